// File: rtl/spio_hss_multiplexer_rx_seq_chk_pkg.sv
// Shared definitions for the HSS multiplexer receive sequence checker.
// Holds the common header values (packet and sequence widths) together with
// the receive buffer geometry and flow-control threshold.
// Optional feature macro: SPIO_HSS_RX_NAK_EN (enables nak generation).

`ifndef SPIO_HSS_MULTIPLEXER_COMMON_H
`define SPIO_HSS_MULTIPLEXER_COMMON_H
`ifndef PKT_BITS
`define PKT_BITS 72
`endif
`ifndef SEQ_BITS
`define SEQ_BITS 7
`endif
`ifndef RX_BUF_LEN
`define RX_BUF_LEN 16
`endif
`ifndef RX_BUF_BITS
`define RX_BUF_BITS 4
`endif
`ifndef RX_CFC_THR
`define RX_CFC_THR 4
`endif
`endif

package spio_hss_multiplexer_rx_seq_chk_pkg;

    localparam int PKT_BITS    = `PKT_BITS;
    localparam int SEQ_BITS    = `SEQ_BITS;
    localparam int RX_BUF_LEN  = `RX_BUF_LEN;
    localparam int RX_BUF_BITS = `RX_BUF_BITS;
    localparam int RX_CFC_THR  = `RX_CFC_THR;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    localparam int RX_PTR_BITS = RX_BUF_BITS + 1;

    typedef logic [PKT_BITS-1:0]    pkt_t;
    typedef logic [SEQ_BITS-1:0]    seq_t;
    typedef logic [RX_PTR_BITS-1:0] ptr_t;

endpackage

// File: rtl/spio_hss_multiplexer_rx_fifo.sv
// Receive packet buffer for the sequence checker: a small circular FIFO with
// registered full/empty flags derived from next-state pointers, plus the
// next-state occupancy so the parent can register its flow-control output.

module spio_hss_multiplexer_rx_fifo
    import spio_hss_multiplexer_rx_seq_chk_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [PKT_BITS-1:0]    wr_data,
    input  logic                   rd_en,
    output logic [PKT_BITS-1:0]    rd_data,
    output logic [RX_PTR_BITS-1:0] count_nxt,
    output logic                   full,
    output logic                   empty
);

    pkt_t mem [RX_BUF_LEN];
    ptr_t wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
    logic do_wr, do_rd;

    assign do_wr      = wr_en && !full;
    assign do_rd      = rd_en && !empty;
    assign wr_ptr_nxt = wr_ptr + RX_PTR_BITS'(do_wr);
    assign rd_ptr_nxt = rd_ptr + RX_PTR_BITS'(do_rd);
    assign count_nxt  = wr_ptr_nxt - rd_ptr_nxt;
    assign rd_data    = mem[rd_ptr[RX_BUF_BITS-1:0]];

    // Storage array is deliberately left out of reset; only pointers matter.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr[RX_BUF_BITS-1:0]] <= wr_data;
        end
    end

    // Pointers advance on write/read; flags look at where the pointers are going.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            wr_ptr <= wr_ptr_nxt;
            rd_ptr <= rd_ptr_nxt;
            full   <= (count_nxt == RX_PTR_BITS'(RX_BUF_LEN));
            empty  <= (count_nxt == '0);
        end
    end

endmodule

// File: rtl/spio_hss_multiplexer_rx_seq_chk.sv
// HSS multiplexer receive sequence checker. Accepts only in-order frames into
// a receive buffer, delivers packets in order over valid/ready, requests
// acks (and optionally naks) from the local frame assembler and drives the
// local channel flow-control bit.
// Optional feature macro: SPIO_HSS_RX_NAK_EN. When undefined, out-of-sequence
// frames are dropped silently and ackn_nak never asserts.

module spio_hss_multiplexer_rx_seq_chk
    import spio_hss_multiplexer_rx_seq_chk_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [PKT_BITS-1:0] rx_pkt_data,
    input  logic [SEQ_BITS-1:0] rx_pkt_seq,
    input  logic                rx_pkt_vld,
    output logic [PKT_BITS-1:0] pkt_data,
    output logic                pkt_vld,
    input  logic                pkt_rdy,
    output logic                ackn_vld,
    output logic                ackn_nak,
    output logic [SEQ_BITS-1:0] ackn_seq,
    input  logic                ackn_rdy,
    output logic                cfc_loc,
    output logic                empty,
    output logic                full
);

    seq_t exp_seq, exp_seq_nxt;
    ptr_t count_nxt, free_nxt;
    logic accept, pkt_rd;
    logic ack_pend, nak_pend;
    logic slot_free, hold, issue_nak, issue_ack;

    assign accept      = rx_pkt_vld && (rx_pkt_seq == exp_seq) && !full;
    assign exp_seq_nxt = accept ? exp_seq + SEQ_BITS'(1) : exp_seq;
    assign pkt_rd      = pkt_vld && pkt_rdy;
    assign free_nxt    = RX_PTR_BITS'(RX_BUF_LEN) - count_nxt;

    // The ack/nak slot is busy while a request waits for ackn_rdy. A held
    // request keeps tracking exp_seq, so it already covers any frame accepted
    // meanwhile and no further ack needs to be queued for it.
    assign slot_free = !ackn_vld || ackn_rdy;
    assign hold      = !slot_free;
    assign issue_nak = slot_free && nak_pend;
    assign issue_ack = slot_free && !nak_pend && ack_pend;

    spio_hss_multiplexer_rx_fifo u_fifo (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (accept),
        .wr_data   (rx_pkt_data),
        .rd_en     (pkt_rd),
        .rd_data   (pkt_data),
        .count_nxt (count_nxt),
        .full      (full),
        .empty     (empty)
    );

    // Expected sequence, packet-valid and flow control, all from next-state values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_seq <= '0;
            pkt_vld <= 1'b0;
            cfc_loc <= 1'b1;
        end else begin
            exp_seq <= exp_seq_nxt;
            pkt_vld <= (count_nxt != '0);
            cfc_loc <= (free_nxt > RX_PTR_BITS'(RX_CFC_THR));
        end
    end

`ifdef SPIO_HSS_RX_NAK_EN
    localparam logic [0:0] SYNC     = 1'b0;
    localparam logic [0:0] NAK_SENT = 1'b1;

    logic [0:0] state;
    logic       drop, nak_trig;

    assign drop     = rx_pkt_vld && !accept;
    assign nak_trig = drop && (state == SYNC);

    // One nak per loss episode: NAK_SENT mutes naks until a frame is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= SYNC;
            nak_pend <= 1'b0;
        end else begin
            if (nak_trig) begin
                state <= NAK_SENT;
            end else if (accept) begin
                state <= SYNC;
            end
            nak_pend <= nak_trig || (nak_pend && !issue_nak);
        end
    end
`else
    assign nak_pend = 1'b0;
`endif

    // Registered ack/nak request; naks win, and any issued request clears ack_pend.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ackn_vld <= 1'b0;
            ackn_nak <= 1'b0;
            ackn_seq <= '0;
            ack_pend <= 1'b0;
        end else begin
            if (hold) begin
                ackn_seq <= exp_seq_nxt;
            end else if (issue_nak || issue_ack) begin
                ackn_vld <= 1'b1;
                ackn_nak <= issue_nak;
                ackn_seq <= exp_seq_nxt;
            end else begin
                ackn_vld <= 1'b0;
            end
            ack_pend <= (hold || issue_nak || issue_ack) ? 1'b0 : (ack_pend || accept);
        end
    end

endmodule
